demux_1to2_buffered: RTL and testbench
======================================

// Module: demux_1to2_buffered
//
// PURPOSE
// Inverse of the 2-to-1 selection path: routes one 32-bit source word to one of
// two destinations, A or B, chosen by Selector. Each destination has a one-entry
// output register with valid/ready handshake, so a stalled consumer never corrupts
// the other path. Sits between the datapath result bus and two independent
// consumers, for example write-back versus memory store staging.
//
// PARAMETERS
// DATA_W  32  width of Num_In, Out_A and Out_B
// CNT_W    8  width of the per-output delivered-word counters (wrap-around)
//
// PORTS
// clk        in   1        rising-edge clock, single clock domain
// rst_n      in   1        synchronous reset, active-low
// Num_In     in   DATA_W   source word
// Selector   in   1        0 = route to A, 1 = route to B; sampled only when In_Valid=1
// In_Valid   in   1        source word valid
// In_Ready   out  1        block accepts Num_In this cycle
// Out_A      out  DATA_W   destination A data
// Valid_A    out  1        Out_A holds an undelivered word
// Ready_A    in   1        destination A consumes Out_A this cycle
// Out_B      out  DATA_W   destination B data
// Valid_B    out  1        Out_B holds an undelivered word
// Ready_B    in   1        destination B consumes Out_B this cycle
// Count_A    out  CNT_W    words delivered on A, modulo 2^CNT_W
// Count_B    out  CNT_W    words delivered on B, modulo 2^CNT_W
//
// BEHAVIOUR
// - Reset is sampled at the rising edge of clk while rst_n=0.
// - Reset values: Out_A=0, Out_B=0, Valid_A=0, Valid_B=0, Count_A=0, Count_B=0.
// - Reset in mid-operation discards pending words. Valid bits and counters clear at that edge.
// - Each slot X (A or B) has two states, EMPTY (Valid_X=0) and FULL (Valid_X=1).
// - Accept: fire_in = In_Valid & In_Ready.
// - Drain: fire_X = Valid_X & Ready_X.
// - In_Ready = Selector ? (~Valid_B | Ready_B) : (~Valid_A | Ready_A).
//   - Combinational in Selector, Valid_X and Ready_X only.
//   - No path from In_Valid to In_Ready.
// - Slot transitions:
//   - EMPTY -> FULL on fire_in to X.
//   - FULL -> EMPTY on fire_X with no load to X in the same cycle.
//   - FULL -> FULL on fire_X together with a load to X: the slot reloads, giving one word per cycle back-to-back.
//   - FULL with Ready_X=0: hold. Out_X and Valid_X are stable until drained.
// - Latency: a word accepted at edge N appears on Out_X with Valid_X=1 after edge N.
// - Out_X keeps its last value after draining. Only Valid_X clears.
// - A load to one slot never affects the other slot's data, valid bit or counter.
// - While In_Valid=0, Selector is don't-care and causes no state change.
// - Count_X increments by 1 at each fire_X and wraps from 2^CNT_W-1 to 0.
// - Simultaneous fire_A, fire_B and fire_in (to either slot) are all legal in one cycle.
//   Both counters update independently.
// - All registers update on the rising edge of clk only. There are no latches.
//
// TESTING
// 1. Reset: hold rst_n=0 for 2 cycles with In_Valid=1 -> all outputs 0; In_Ready=1 on the first cycle after release.
// 2. Routing: Num_In=32'd3000000, Selector=0, one-cycle In_Valid, Ready_A=1 ->
//    next cycle Out_A=3000000, Valid_A=1, Valid_B=0; one cycle later Valid_A=0, Count_A=1.
//    Repeat with 32'd4 and Selector=1 -> Out_B=4, Count_B=1, Count_A unchanged.
// 3. Backpressure isolation: Ready_B=0; send 32'd902 with Selector=1 -> Valid_B=1, held for 5 cycles.
//    - A second word, 32'd5254513 with Selector=1 -> In_Ready=0, not accepted.
//    - Switching Selector=0 -> In_Ready=1, word lands on A while Out_B stays 902.
// 4. Streaming: 4 consecutive words 1..4 to A with Ready_A=1 -> In_Ready stays 1, Out_A=1,2,3,4
//    on consecutive cycles, Count_A=4; repeat with simultaneous drain and load on B -> no bubble.
// 5. Wrap and mid-op reset: with CNT_W=2, deliver 5 words on A -> Count_A=1.
//    Then load B with Ready_B=0 and pulse rst_n=0 for 1 cycle -> Valid_B=0, Count_A=0, Out_B=0.

Source files
------------

// File: rtl/demux_1to2_buffered.sv
// rtl/demux_1to2_buffered.sv - 1-to-2 demultiplexer with a one-entry valid/ready output register per destination
// A stalled destination only blocks new words steered to it; the other slot keeps flowing.
module demux_1to2_buffered #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] Num_In,
    input  logic              Selector,
    input  logic              In_Valid,
    output logic              In_Ready,
    output logic [DATA_W-1:0] Out_A,
    output logic              Valid_A,
    input  logic              Ready_A,
    output logic [DATA_W-1:0] Out_B,
    output logic              Valid_B,
    input  logic              Ready_B,
    output logic [CNT_W-1:0]  Count_A,
    output logic [CNT_W-1:0]  Count_B
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    slot_state_t       state_a, state_a_next;
    slot_state_t       state_b, state_b_next;
    logic [DATA_W-1:0] data_a, data_b;
    logic [CNT_W-1:0]  cnt_a, cnt_b;
    logic              fire_in, load_a, load_b, fire_a, fire_b;

    // In_Ready must not depend on In_Valid, so it is derived from the selected slot only.
    assign In_Ready = Selector ? (~Valid_B | Ready_B) : (~Valid_A | Ready_A);
    assign fire_in  = In_Valid & In_Ready;
    assign load_a   = fire_in & ~Selector;
    assign load_b   = fire_in & Selector;
    assign fire_a   = Valid_A & Ready_A;
    assign fire_b   = Valid_B & Ready_B;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_a <= EMPTY;
            state_b <= EMPTY;
        end else begin
            state_a <= state_a_next;
            state_b <= state_b_next;
        end
    end

    always_comb begin
        state_a_next = state_a;
        if (load_a)
            state_a_next = FULL;
        else if (fire_a)
            state_a_next = EMPTY;
    end

    always_comb begin
        state_b_next = state_b;
        if (load_b)
            state_b_next = FULL;
        else if (fire_b)
            state_b_next = EMPTY;
    end

    always_comb begin
        Valid_A = (state_a == FULL);
        Valid_B = (state_b == FULL);
        Out_A   = data_a;
        Out_B   = data_b;
        Count_A = cnt_a;
        Count_B = cnt_b;
    end

    // Data is only written on a load, so Out_X keeps its last word after a drain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_a <= '0;
            data_b <= '0;
            cnt_a  <= '0;
            cnt_b  <= '0;
        end else begin
            if (load_a)
                data_a <= Num_In;
            if (load_b)
                data_b <= Num_In;
            if (fire_a)
                cnt_a <= cnt_a + CNT_ONE;
            if (fire_b)
                cnt_b <= cnt_b + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_demux_1to2_buffered.sv
// tb/tb_demux_1to2_buffered.sv - directed self-checking bench for demux_1to2_buffered
module tb_demux_1to2_buffered;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] Num_In;
    logic        Selector, In_Valid, Ready_A, Ready_B;
    logic        In_Ready, Valid_A, Valid_B;
    logic [31:0] Out_A, Out_B;
    logic [7:0]  Count_A, Count_B;
    logic        In_Ready2, Valid_A2, Valid_B2;
    logic [31:0] Out_A2, Out_B2;
    logic [1:0]  Count_A2, Count_B2;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    demux_1to2_buffered dut (
        .clk(clk), .rst_n(rst_n), .Num_In(Num_In), .Selector(Selector),
        .In_Valid(In_Valid), .In_Ready(In_Ready),
        .Out_A(Out_A), .Valid_A(Valid_A), .Ready_A(Ready_A),
        .Out_B(Out_B), .Valid_B(Valid_B), .Ready_B(Ready_B),
        .Count_A(Count_A), .Count_B(Count_B)
    );

    demux_1to2_buffered #(.DATA_W(32), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .Num_In(Num_In), .Selector(Selector),
        .In_Valid(In_Valid), .In_Ready(In_Ready2),
        .Out_A(Out_A2), .Valid_A(Valid_A2), .Ready_A(Ready_A),
        .Out_B(Out_B2), .Valid_B(Valid_B2), .Ready_B(Ready_B),
        .Count_A(Count_A2), .Count_B(Count_B2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // 1. reset held two cycles with In_Valid high
        rst_n = 1'b0; In_Valid = 1'b1; Num_In = 32'd77; Selector = 1'b0;
        Ready_A = 1'b0; Ready_B = 1'b0;
        tick(); tick();
        chk("rst_out_a", Out_A, 0);
        chk("rst_out_b", Out_B, 0);
        chk("rst_valid_a", Valid_A, 0);
        chk("rst_valid_b", Valid_B, 0);
        chk("rst_count_a", Count_A, 0);
        chk("rst_count_b", Count_B, 0);
        rst_n = 1'b1; In_Valid = 1'b0;
        #1;
        chk("rst_in_ready", In_Ready, 1);

        // 2. routing to A, then to B
        Num_In = 32'd3000000; Selector = 1'b0; In_Valid = 1'b1; Ready_A = 1'b1;
        tick();
        In_Valid = 1'b0;
        chk("route_out_a", Out_A, 3000000);
        chk("route_valid_a", Valid_A, 1);
        chk("route_valid_b", Valid_B, 0);
        tick();
        chk("route_drain_a", Valid_A, 0);
        chk("route_count_a", Count_A, 1);
        Num_In = 32'd4; Selector = 1'b1; In_Valid = 1'b1; Ready_B = 1'b1;
        tick();
        In_Valid = 1'b0;
        chk("route_out_b", Out_B, 4);
        chk("route_valid_b2", Valid_B, 1);
        tick();
        chk("route_drain_b", Valid_B, 0);
        chk("route_count_b", Count_B, 1);
        chk("route_count_a_kept", Count_A, 1);
        chk("route_out_a_kept", Out_A, 3000000);

        // 3. backpressure on B does not block A
        Ready_B = 1'b0; Num_In = 32'd902; Selector = 1'b1; In_Valid = 1'b1;
        tick();
        In_Valid = 1'b0;
        Selector = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            Selector = ~Selector;
        end
        chk("bp_valid_b_held", Valid_B, 1);
        chk("bp_out_b_held", Out_B, 902);
        chk("bp_count_b_held", Count_B, 1);
        Num_In = 32'd5254513; Selector = 1'b1; In_Valid = 1'b1;
        #1;
        chk("bp_in_ready_b", In_Ready, 0);
        tick();
        chk("bp_no_accept", Out_B, 902);
        Selector = 1'b0;
        #1;
        chk("bp_in_ready_a", In_Ready, 1);
        tick();
        In_Valid = 1'b0;
        chk("bp_out_a", Out_A, 5254513);
        chk("bp_valid_a", Valid_A, 1);
        chk("bp_out_b_iso", Out_B, 902);
        chk("bp_valid_b_iso", Valid_B, 1);
        tick();
        chk("bp_count_a", Count_A, 2);
        Ready_B = 1'b1;
        tick();
        chk("bp_count_b", Count_B, 2);
        chk("bp_valid_b_drained", Valid_B, 0);

        // 4. back-to-back streaming on A, then on B
        Ready_A = 1'b1; Selector = 1'b0; In_Valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            Num_In = i;
            #1;
            chk("stream_a_in_ready", In_Ready, 1);
            tick();
            chk("stream_a_out", Out_A, i);
            chk("stream_a_valid", Valid_A, 1);
        end
        In_Valid = 1'b0;
        tick();
        chk("stream_a_count", Count_A, 6);
        chk("stream_a_empty", Valid_A, 0);
        Ready_B = 1'b1; Selector = 1'b1; In_Valid = 1'b1;
        for (int i = 11; i <= 14; i++) begin
            Num_In = i;
            #1;
            chk("stream_b_in_ready", In_Ready, 1);
            tick();
            chk("stream_b_out", Out_B, i);
        end
        In_Valid = 1'b0;
        tick();
        chk("stream_b_count", Count_B, 6);

        // 5. counter wrap (2-bit instance) and mid-operation reset
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rst2_count_a", Count_A, 0);
        Selector = 1'b0; In_Valid = 1'b1; Ready_A = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            Num_In = 100 + i;
            tick();
        end
        In_Valid = 1'b0;
        tick();
        chk("wrap_count_a2", Count_A2, 1);
        chk("wrap_count_a8", Count_A, 5);
        Ready_B = 1'b0; Selector = 1'b1; Num_In = 32'd55; In_Valid = 1'b1;
        tick();
        In_Valid = 1'b0;
        chk("midrst_loaded", Valid_B2, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst_valid_b", Valid_B2, 0);
        chk("midrst_count_a", Count_A2, 0);
        chk("midrst_out_b", Out_B2, 0);

        // simultaneous drain of both slots with a reload of A
        Ready_A = 1'b0; Ready_B = 1'b0; In_Valid = 1'b1;
        Selector = 1'b0; Num_In = 32'd7;
        tick();
        Selector = 1'b1; Num_In = 32'd8;
        tick();
        Ready_A = 1'b1; Ready_B = 1'b1; Selector = 1'b0; Num_In = 32'd9;
        tick();
        In_Valid = 1'b0;
        chk("sim_count_a", Count_A, 1);
        chk("sim_count_b", Count_B, 1);
        chk("sim_out_a", Out_A, 9);
        chk("sim_valid_a", Valid_A, 1);
        chk("sim_valid_b", Valid_B, 0);
        chk("sim_out_b_kept", Out_B, 8);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
